iir_sequencer: RTL

IIR_SEQUENCER -- requirements
Module: iir_sequencer

---
 rtl/iir_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/iir_sequencer.sv
// Direct-form-I IIR filter evaluated by one time-shared multiplier. Each sample
// is accumulated over 2*stages+1 cycles, with double-buffered coefficient banks.
module iir_sequencer #(
  parameter int aw     = 18,
  parameter int sw     = 18,
  parameter int stages = 2
) (
  input  logic                          clk,
  input  logic                          rst_b,
  input  logic                          sample_valid,
  input  logic signed [aw-1:0]          audio_in,
  output logic signed [aw-1:0]          audio_out,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          overrun,
  input  logic                          coef_we,
  input  logic                          coef_sel,
  input  logic [$clog2(stages+1)-1:0]   coef_idx,
  input  logic signed [sw-1:0]          coef_data,
  input  logic                          coef_commit,
  input  logic                          flush
);

  localparam int iw   = $clog2(stages + 1);
  localparam int tw   = $clog2(2 * stages + 1);
  localparam int pw   = aw + sw;
  localparam int accw = pw + tw;
  localparam int rw   = accw - (sw - 2);

  localparam logic [tw-1:0]        last_tap = tw'(2 * stages);
  localparam logic [sw-1:0]        coef_one = {{(sw-1){1'b0}}, 1'b1} << (sw - 2);
  localparam logic signed [rw-1:0] sat_hi   = {{(rw-aw+1){1'b0}}, {(aw-1){1'b1}}};
  localparam logic signed [rw-1:0] sat_lo   = {{(rw-aw+1){1'b1}}, {(aw-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    WRITE
  } state_t;

  state_t state;

  logic [tw-1:0]          tap;
  logic signed [accw-1:0] acc;
  logic signed [accw-1:0] acc_next;
  logic                   commit_pending;
  logic                   flush_pending;

  logic signed [sw-1:0] b_shadow      [0:stages];
  logic signed [sw-1:0] b_shadow_next [0:stages];
  logic signed [sw-1:0] b_active      [0:stages];
  logic signed [sw-1:0] a_shadow      [1:stages];
  logic signed [sw-1:0] a_shadow_next [1:stages];
  logic signed [sw-1:0] a_active      [1:stages];

  logic signed [aw-1:0] x_hist [0:stages];
  logic signed [aw-1:0] y_hist [1:stages];

  logic signed [sw-1:0] coef_op;
  logic signed [aw-1:0] data_op;
  logic                 sub_op;
  logic signed [pw-1:0] prod;
  logic signed [rw-1:0] shifted;
  logic signed [aw-1:0] result;

  logic bank_update;
  logic commit_now;
  logic flush_now;

  // Shadow-bank write decode; out-of-range indices simply never match.
  genvar gi;
  generate
    for (gi = 0; gi <= stages; gi++) begin : g_b_shadow
      assign b_shadow_next[gi] = (coef_we && !coef_sel && coef_idx == iw'(gi))
                                 ? coef_data : b_shadow[gi];
    end
    for (gi = 1; gi <= stages; gi++) begin : g_a_shadow
      assign a_shadow_next[gi] = (coef_we && coef_sel && coef_idx == iw'(gi))
                                 ? coef_data : a_shadow[gi];
    end
  endgenerate

  assign busy        = (state != IDLE);
  assign bank_update = (state == IDLE) && !sample_valid;
  assign commit_now  = commit_pending || coef_commit;
  assign flush_now   = flush_pending || flush;

  always_comb begin
    coef_op = '0;
    data_op = '0;
    sub_op  = 1'b0;
    for (int k = 0; k <= stages; k++) begin
      if (tap == tw'(k)) begin
        coef_op = b_active[k];
        data_op = x_hist[k];
      end
    end
    for (int k = 1; k <= stages; k++) begin
      if (tap == tw'(stages + k)) begin
        coef_op = a_active[k];
        data_op = y_hist[k];
        sub_op  = 1'b1;
      end
    end
  end

  assign prod = pw'(coef_op) * pw'(data_op);

  always_comb begin
    acc_next = sub_op ? (acc - accw'(prod)) : (acc + accw'(prod));
  end

  // Dropping the low fraction bits is an arithmetic shift rounding toward -inf.
  assign shifted = acc_next[accw-1:sw-2];

  always_comb begin
    result = shifted[aw-1:0];
    if (shifted > sat_hi) begin
      result = sat_hi[aw-1:0];
    end else if (shifted < sat_lo) begin
      result = sat_lo[aw-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state          <= IDLE;
      tap            <= '0;
      acc            <= '0;
      audio_out      <= '0;
      out_valid      <= 1'b0;
      overrun        <= 1'b0;
      commit_pending <= 1'b0;
      flush_pending  <= 1'b0;
      for (int k = 0; k <= stages; k++) begin
        x_hist[k]   <= '0;
        b_shadow[k] <= (k == 0) ? coef_one : '0;
        b_active[k] <= (k == 0) ? coef_one : '0;
      end
      for (int k = 1; k <= stages; k++) begin
        y_hist[k]   <= '0;
        a_shadow[k] <= '0;
        a_active[k] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      overrun   <= sample_valid && (state != IDLE);

      for (int k = 0; k <= stages; k++) begin
        b_shadow[k] <= b_shadow_next[k];
      end
      for (int k = 1; k <= stages; k++) begin
        a_shadow[k] <= a_shadow_next[k];
      end

      // The active bank copies the post-write shadow so a same-cycle write lands.
      if (bank_update && commit_now) begin
        commit_pending <= 1'b0;
        for (int k = 0; k <= stages; k++) begin
          b_active[k] <= b_shadow_next[k];
        end
        for (int k = 1; k <= stages; k++) begin
          a_active[k] <= a_shadow_next[k];
        end
      end else if (coef_commit) begin
        commit_pending <= 1'b1;
      end

      if (bank_update && flush_now) begin
        flush_pending <= 1'b0;
        for (int k = 0; k <= stages; k++) begin
          x_hist[k] <= '0;
        end
        for (int k = 1; k <= stages; k++) begin
          y_hist[k] <= '0;
        end
      end else if (flush) begin
        flush_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (sample_valid) begin
            x_hist[0] <= audio_in;
            acc       <= '0;
            tap       <= '0;
            state     <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          tap <= tap + 1'b1;
          // The final product is folded in combinationally so the result
          // appears as WRITE is entered, keeping latency at 2*stages+2.
          if (tap == last_tap) begin
            audio_out <= result;
            out_valid <= 1'b1;
            state     <= WRITE;
          end
        end
        WRITE: begin
          for (int k = 1; k <= stages; k++) begin
            x_hist[k] <= x_hist[k-1];
          end
          y_hist[1] <= audio_out;
          for (int k = 2; k <= stages; k++) begin
            y_hist[k] <= y_hist[k-1];
          end
          tap   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
